gpsreceiver2_tx: RTL and testbench
==================================

// Module: gpsreceiver2_tx
// PURPOSE
//  Bit-serial transmitter, counterpart of the GPS sample receiver: reads bytes from a
//  2 KiB byte buffer and emits them as a clock/sync/data stream with the same framing
//  the receiver accepts. Used for loopback self-test of the receive path and for
//  replaying captured sample files. Sits beside the receive path, driven by CSR control.
// PARAMETERS
//  ADR_W     11   buffer byte-address width (2048 bytes)
//  CNT_W     16   width of the transmitted-byte counter
// PORTS
//  sys_clk      in   1      single clock; all logic on rising edge
//  sys_rst      in   1      synchronous, active-high reset
//  start        in   1      1-cycle pulse: begin transmission (ignored unless idle)
//  stop         in   1      1-cycle pulse: abort immediately
//  loop_en      in   1      1 = wrap to base_adr after last byte, run until stop
//  prbs_mode    in   1      1 = send PRBS-7 instead of buffer data (see CONFIGURATION)
//  base_adr     in   ADR_W  first byte address, latched at start
//  length       in   ADR_W+1 bytes per pass (1..2048), latched at start; 0 = start ignored
//  clkdiv       in   8      half bit period = clkdiv+1 sys_clk cycles, latched at start
//  txb_adr      out  ADR_W  buffer read address (registered)
//  txb_dat      in   8      buffer read data, valid 1 cycle after txb_adr
//  gps_tx_clk   out  1      bit clock; receiver samples on rising edge
//  gps_tx_sync  out  1      high during bit 7 (first bit) of every byte
//  gps_tx_data  out  1      serial data, MSB first, changes only on falling edge
//  busy         out  1      high from start acceptance until idle
//  done         out  1      1-cycle pulse at normal end of a non-loop pass
//  tx_count     out  CNT_W  bytes fully transmitted since last start, wraps
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, tx_count 0, PRBS state 7'h7F.
//  - FSM: IDLE -> FETCH (start && length!=0) -> RUN -> IDLE (last bit of last byte
//    completes, loop_en=0; done pulses on the IDLE-entry cycle).
//  - Start sampled cycle S: txb_adr=base_adr at S+1, data captured S+2, RUN at S+3 with
//    gps_tx_clk=0, gps_tx_data=bit7, gps_tx_sync=1. tx_count cleared at S+1.
//  - Bit timing: low phase clkdiv+1 cycles, high phase clkdiv+1 cycles; bit period
//    2*(clkdiv+1). Data/sync update on the cycle gps_tx_clk goes 1->0.
//  - Double buffer: shift register + next-byte register. On each byte load, next
//    address issued; fetch (2 cycles) always completes within one byte (>=16 cycles),
//    so bytes are gapless back to back.
//  - Address: base_adr + index, modulo 2^ADR_W (wraps 2047->0 inside a pass).
//  - tx_count increments when a byte's 8th bit period ends (falling edge of 8th bit).
//  - loop_en sampled at each pass end; index returns to 0 with no gap.
//  - stop (any state): next cycle FSM IDLE, clk/sync/data 0, busy 0, no done pulse,
//    tx_count holds. stop and start same cycle: stop wins.
//  - start while busy: ignored. clkdiv/base/length changes mid-run: no effect.
//  - sys_rst mid-run: same as reset values next cycle, no done.
// CONFIGURATION
//  GPSTX_PRBS_EN defined: prbs_mode=1 (latched at start) replaces txb_dat with
//   PRBS-7 (x^7+x^6+1, seed 7'h7F at start), one bit per bit period; length/loop and
//   byte framing/sync unchanged; txb_adr still advances.
//  Undefined: prbs_mode ignored, no LFSR logic synthesized.
// STRUCTURE
//  - Shared package gpsreceiver2_pkg: FSM state encoding (IDLE/FETCH/RUN), ADR_W,
//    CNT_W defaults, PRBS seed/taps constants.
//  - Sub-module gpsreceiver2_tx_clkgen: divider producing gps_tx_clk plus 1-cycle
//    fall_tick/rise_tick enables; cleared by stop/reset, restarted on RUN entry.
// TESTING
//  1 base=0,len=2,clkdiv=0,buf={A5,3C}: start -> bits 10100101 00111100 on rising
//    edges, sync on bits 0 and 8, bit period 2 cycles, done 32 cycles after RUN,
//    tx_count=2.
//  2 clkdiv=3,len=1,buf[7]=81, base=7: clk low 4/high 4; first bit at S+3; txb_adr=7.
//  3 base=2046,len=4: txb_adr sequence 2046,2047,0,1; no inter-byte gap.
//  4 loop_en=1,len=3: bytes repeat continuously; stop mid-byte -> outputs 0 next
//    cycle, busy 0, no done, tx_count holds partial-pass value.
//  5 length=0 start -> busy stays 0; start while busy -> no effect; start+stop
//    same cycle -> stays IDLE.
//  6 Loopback into receiver with GPSTX_PRBS_EN, prbs_mode=1, len=16: receiver buffer
//    matches PRBS-7 from seed 7F; rebuilt without macro, buffer data sent instead.

Source files
------------

// File: rtl/gpsreceiver2_pkg.sv
// Shared FSM encoding, default widths and PRBS-7 constants for the GPS sample transmitter.
package gpsreceiver2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_RUN   = 2'd2
    } tx_state_t;

    localparam int ADR_W_DEF = 11;
    localparam int CNT_W_DEF = 16;

    localparam logic [6:0] PRBS_SEED = 7'h7F;
    localparam logic [6:0] PRBS_TAPS = 7'b110_0000;   // x^7 + x^6 + 1

    function automatic logic prbs7_fb(input logic [6:0] s);
        return ^(s & PRBS_TAPS);
    endfunction

endpackage

// File: rtl/gpsreceiver2_tx_clkgen.sv
// Bit-clock divider: half period = div+1 cycles, with fall/rise enables for the edge about to happen.
// Latency: ticks are combinational from the counter; first rise div+1 cycles after en goes high.
// Backpressure: none; held low and cleared whenever en is low or clr/reset is asserted.
module gpsreceiver2_tx_clkgen (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] div,
    output logic       tx_clk,
    output logic       fall_tick,
    output logic       rise_tick
);

    logic [7:0] cnt;
    logic       half_end;

    assign half_end  = en && (cnt == div);
    assign rise_tick = half_end && !tx_clk;
    assign fall_tick = half_end && tx_clk;

    always_ff @(posedge sys_clk) begin
        if (sys_rst || clr || !en) begin
            cnt    <= '0;
            tx_clk <= 1'b0;
        end else if (cnt == div) begin
            cnt    <= '0;
            tx_clk <= !tx_clk;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/gpsreceiver2_tx.sv
// Bit-serial buffer transmitter (PRBS-7 source when GPSTX_PRBS_EN is defined), MSB first with sync on bit 7.
// Latency: first bit on the wire 3 cycles after start; bytes gapless via shift + next-byte registers.
// Backpressure: none; buffer is a fixed 1-cycle synchronous read, stop aborts on the next cycle.
module gpsreceiver2_tx
    import gpsreceiver2_pkg::*;
#(
    parameter int ADR_W = ADR_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_en,
    input  logic             prbs_mode,
    input  logic [ADR_W-1:0] base_adr,
    input  logic [ADR_W:0]   length,
    input  logic [7:0]       clkdiv,
    output logic [ADR_W-1:0] txb_adr,
    input  logic [7:0]       txb_dat,
    output logic             gps_tx_clk,
    output logic             gps_tx_sync,
    output logic             gps_tx_data,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] tx_count
);

    tx_state_t        state;
    logic [ADR_W-1:0] base_q;
    logic [ADR_W-1:0] last_q;
    logic [ADR_W-1:0] cur_idx;
    logic [7:0]       div_q;
    logic [7:0]       shift_q;
    logic [7:0]       nxt_q;
    logic [2:0]       bit_idx;
    logic [1:0]       rd_pend;
    logic             fall_tick;
    logic             rise_tick;
    logic             acc_start;
    logic             bit_end;
    logic             byte_end;
    logic             pass_end;
    logic             prbs_on;
    logic             prbs_bit;
    logic             unused_sigs;

    function automatic logic [ADR_W-1:0] idx_inc(input logic [ADR_W-1:0] i,
                                                 input logic [ADR_W-1:0] last);
        return (i == last) ? '0 : i + 1'b1;
    endfunction

    assign acc_start = (state == ST_IDLE) && start && !stop && (length != '0);
    assign bit_end   = (state == ST_RUN) && fall_tick && !stop;
    assign byte_end  = bit_end && (bit_idx == 3'd7);
    assign pass_end  = byte_end && (cur_idx == last_q) && !loop_en;

    gpsreceiver2_tx_clkgen u_clkgen (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .clr       (stop),
        .en        (state == ST_RUN),
        .div       (div_q),
        .tx_clk    (gps_tx_clk),
        .fall_tick (fall_tick),
        .rise_tick (rise_tick)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= ST_IDLE;
            base_q      <= '0;
            last_q      <= '0;
            cur_idx     <= '0;
            div_q       <= '0;
            shift_q     <= '0;
            nxt_q       <= '0;
            bit_idx     <= '0;
            rd_pend     <= '0;
            txb_adr     <= '0;
            gps_tx_sync <= 1'b0;
            gps_tx_data <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            tx_count    <= '0;
        end else begin
            done    <= 1'b0;
            rd_pend <= {rd_pend[0], 1'b0};
            if (stop) begin
                state       <= ST_IDLE;
                busy        <= 1'b0;
                gps_tx_sync <= 1'b0;
                gps_tx_data <= 1'b0;
                rd_pend     <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (acc_start) begin
                            state    <= ST_FETCH;
                            busy     <= 1'b1;
                            base_q   <= base_adr;
                            // length 2048 wraps to 0 here, so last index becomes 2047
                            last_q   <= length[ADR_W-1:0] - 1'b1;
                            div_q    <= clkdiv;
                            txb_adr  <= base_adr;
                            rd_pend  <= 2'b01;
                            tx_count <= '0;
                        end
                    end
                    ST_FETCH: begin
                        if (rd_pend[1]) begin
                            state       <= ST_RUN;
                            shift_q     <= txb_dat;
                            bit_idx     <= '0;
                            cur_idx     <= '0;
                            gps_tx_sync <= 1'b1;
                            gps_tx_data <= prbs_on ? prbs_bit : txb_dat[7];
                            txb_adr     <= base_q + idx_inc('0, last_q);
                            rd_pend     <= 2'b01;
                        end
                    end
                    ST_RUN: begin
                        if (rd_pend[1]) begin
                            nxt_q <= txb_dat;
                        end
                        if (byte_end) begin
                            tx_count <= tx_count + 1'b1;
                            if (pass_end) begin
                                state       <= ST_IDLE;
                                busy        <= 1'b0;
                                done        <= 1'b1;
                                gps_tx_sync <= 1'b0;
                                gps_tx_data <= 1'b0;
                            end else begin
                                // prefetch one byte ahead so the next load never waits
                                shift_q     <= nxt_q;
                                bit_idx     <= '0;
                                cur_idx     <= idx_inc(cur_idx, last_q);
                                gps_tx_sync <= 1'b1;
                                gps_tx_data <= prbs_on ? prbs_bit : nxt_q[7];
                                txb_adr     <= base_q + idx_inc(idx_inc(cur_idx, last_q), last_q);
                                rd_pend     <= 2'b01;
                            end
                        end else if (bit_end) begin
                            shift_q     <= {shift_q[6:0], 1'b0};
                            bit_idx     <= bit_idx + 1'b1;
                            gps_tx_sync <= 1'b0;
                            gps_tx_data <= prbs_on ? prbs_bit : shift_q[6];
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef GPSTX_PRBS_EN
    logic [6:0] lfsr;
    logic       prbs_q;
    logic       first_load;
    logic       new_bit;

    assign first_load  = (state == ST_FETCH) && rd_pend[1] && !stop;
    assign new_bit     = first_load || (bit_end && !pass_end);
    assign prbs_on     = prbs_q;
    assign prbs_bit    = prbs7_fb(lfsr);
    assign unused_sigs = rise_tick;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            lfsr   <= PRBS_SEED;
            prbs_q <= 1'b0;
        end else if (acc_start) begin
            lfsr   <= PRBS_SEED;
            prbs_q <= prbs_mode;
        end else if (new_bit) begin
            lfsr <= {lfsr[5:0], prbs_bit};
        end
    end
`else
    assign prbs_on     = 1'b0;
    assign prbs_bit    = 1'b0;
    assign unused_sigs = rise_tick ^ prbs_mode;
`endif

endmodule

// File: tb/tb_gpsreceiver2_tx.sv
// Directed bench for gpsreceiver2_tx: a sync-read buffer model feeds the DUT and a small
// receiver model rebuilds bytes from the serial stream on gps_tx_clk rising edges.
module tb_gpsreceiver2_tx;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        start, stop, loop_en, prbs_mode;
    logic [10:0] base_adr;
    logic [11:0] length;
    logic [7:0]  clkdiv;
    logic [10:0] txb_adr;
    logic [7:0]  txb_dat;
    logic        gps_tx_clk, gps_tx_sync, gps_tx_data, busy, done;
    logic [15:0] tx_count;

    logic [7:0]  mem [0:2047];

    int n_tests = 0;
    int n_fail  = 0;
    int ncyc    = 0;

    logic [7:0]  rx_q [$];
    logic [10:0] adr_q [$];
    logic [7:0]  rx_sh = '0;
    logic        prev_clk = 1'b0;
    logic [10:0] prev_adr = '0;
    int bitcnt = 0, sync_err = 0, sync_cnt = 0, done_cnt = 0;
    int run_len = 0, last_hi = 0, last_lo = 0;

    gpsreceiver2_tx dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .start       (start),
        .stop        (stop),
        .loop_en     (loop_en),
        .prbs_mode   (prbs_mode),
        .base_adr    (base_adr),
        .length      (length),
        .clkdiv      (clkdiv),
        .txb_adr     (txb_adr),
        .txb_dat     (txb_dat),
        .gps_tx_clk  (gps_tx_clk),
        .gps_tx_sync (gps_tx_sync),
        .gps_tx_data (gps_tx_data),
        .busy        (busy),
        .done        (done),
        .tx_count    (tx_count)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) txb_dat <= mem[txb_adr];

    // receiver model and phase-length monitor
    always @(negedge sys_clk) begin
        if (gps_tx_clk != prev_clk) begin
            if (prev_clk) last_hi = run_len;
            else          last_lo = run_len;
            run_len = 1;
        end else begin
            run_len++;
        end
        if (gps_tx_clk && !prev_clk) begin
            if (gps_tx_sync != (bitcnt == 0)) sync_err++;
            if (gps_tx_sync) begin
                bitcnt = 0;
                sync_cnt++;
            end
            rx_sh = {rx_sh[6:0], gps_tx_data};
            bitcnt++;
            if (bitcnt == 8) begin
                rx_q.push_back(rx_sh);
                bitcnt = 0;
            end
        end
        if (txb_adr != prev_adr) adr_q.push_back(txb_adr);
        prev_adr = txb_adr;
        prev_clk = gps_tx_clk;
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge sys_clk);
        ncyc++;
    endtask

    task automatic mon_clear();
        rx_q.delete();
        adr_q.delete();
        bitcnt   = 0;
        sync_err = 0;
        sync_cnt = 0;
        done_cnt = 0;
    endtask

    // leaves the bench in the cycle after the start edge, ncyc = 1
    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        ncyc  = 1;
    endtask

    task automatic wait_done(input int max);
        while (!done && ncyc < max) step();
    endtask

    task automatic setup(input logic [10:0] b, input logic [11:0] l, input logic [7:0] d);
        base_adr = b;
        length   = l;
        clkdiv   = d;
        mon_clear();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] adr_before;
        logic [6:0]  s;
        logic [7:0]  exp_b;
        logic        fb;

        sys_rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; prbs_mode = 1'b0;
        base_adr = '0; length = '0; clkdiv = '0;
        for (int i = 0; i < 2048; i++) mem[i] = 8'(i * 37 + 5);
        repeat (3) step();
        check("rst_outs", {gps_tx_clk, gps_tx_sync, gps_tx_data, busy, done}, 5'b0);
        check("rst_count", tx_count, 0);
        check("rst_adr", txb_adr, 0);
        sys_rst = 1'b0;
        step();

        // 1: two bytes, fastest bit clock
        mem[0] = 8'hA5; mem[1] = 8'h3C;
        setup(11'd0, 12'd2, 8'd0);
        pulse_start();
        check("t1_adr_s1", txb_adr, 0);
        check("t1_busy", busy, 1);
        check("t1_count_clr", tx_count, 0);
        step(); step();
        check("t1_first_bit", {gps_tx_clk, gps_tx_sync, gps_tx_data}, 3'b011);
        wait_done(60);
        check("t1_done_cyc", ncyc, 35);
        check("t1_done", done, 1);
        check("t1_busy_end", busy, 0);
        check("t1_nbytes", rx_q.size(), 2);
        check("t1_b0", rx_q[0], 8'hA5);
        check("t1_b1", rx_q[1], 8'h3C);
        check("t1_sync_pos", sync_err, 0);
        check("t1_sync_cnt", sync_cnt, 2);
        check("t1_period", {last_lo[7:0], last_hi[7:0]}, 16'h0101);
        check("t1_count", tx_count, 2);
        step();

        // 2: one byte, clkdiv 3
        mem[7] = 8'h81;
        setup(11'd7, 12'd1, 8'd3);
        pulse_start();
        check("t2_adr", txb_adr, 7);
        step(); step();
        check("t2_first_bit", {gps_tx_clk, gps_tx_sync, gps_tx_data}, 3'b011);
        wait_done(100);
        check("t2_done_cyc", ncyc, 67);
        check("t2_byte", rx_q[0], 8'h81);
        check("t2_phases", {last_lo[7:0], last_hi[7:0]}, 16'h0404);
        check("t2_count", tx_count, 1);
        step();

        // 3: address wraps inside a pass
        mem[2046] = 8'h11; mem[2047] = 8'h22; mem[0] = 8'h33; mem[1] = 8'h44;
        setup(11'd2046, 12'd4, 8'd0);
        pulse_start();
        wait_done(100);
        check("t3_done_cyc", ncyc, 67);
        check("t3_adr0", adr_q[0], 2046);
        check("t3_adr1", adr_q[1], 2047);
        check("t3_adr2", adr_q[2], 0);
        check("t3_adr3", adr_q[3], 1);
        check("t3_bytes", {rx_q[0], rx_q[1], rx_q[2], rx_q[3]}, 32'h11223344);
        check("t3_count", tx_count, 4);
        step();

        // 4: loop mode then stop mid-byte
        mem[16] = 8'hC1; mem[17] = 8'hC2; mem[18] = 8'hC3;
        setup(11'd16, 12'd3, 8'd0);
        loop_en = 1'b1;
        pulse_start();
        while (ncyc < 116) step();
        check("t4_pre_stop", {gps_tx_clk, gps_tx_sync, gps_tx_data, busy}, 4'b1111);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("t4_stop_outs", {gps_tx_clk, gps_tx_sync, gps_tx_data, busy, done}, 5'b0);
        check("t4_count", tx_count, 7);
        repeat (5) step();
        loop_en = 1'b0;
        check("t4_count_hold", tx_count, 7);
        check("t4_no_done", done_cnt, 0);
        check("t4_nbytes", rx_q.size(), 7);
        check("t4_wrap", {rx_q[2], rx_q[3], rx_q[6]}, 24'hC3C1C1);

        // 5: zero length, start while busy, start+stop together
        setup(11'd16, 12'd0, 8'd0);
        pulse_start();
        check("t5_len0_busy", busy, 0);
        step();
        check("t5_len0_busy2", busy, 0);
        mem[32] = 8'h5A; mem[33] = 8'hF0;
        setup(11'd32, 12'd2, 8'd0);
        pulse_start();
        while (ncyc < 10) step();
        base_adr = 11'h100; length = 12'd1; clkdiv = 8'd5; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(60);
        check("t5_busy_start_done", ncyc, 35);
        check("t5_busy_start_bytes", {rx_q[0], rx_q[1]}, 16'h5AF0);
        check("t5_busy_start_count", tx_count, 2);
        step();
        adr_before = txb_adr;
        base_adr = 11'h300;
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check("t5_startstop_busy", busy, 0);
        step();
        check("t5_startstop_adr", txb_adr, {21'd0, adr_before});

        // synchronous reset mid-run
        setup(11'd32, 12'd2, 8'd0);
        pulse_start();
        while (ncyc < 20) step();
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        check("rst_mid_outs", {gps_tx_clk, gps_tx_sync, gps_tx_data, busy, done}, 5'b0);
        check("rst_mid_count", tx_count, 0);
        check("rst_mid_adr", txb_adr, 0);
        repeat (30) step();
        check("rst_mid_no_done", done_cnt, 0);

        // 6: prbs_mode over 16 bytes
        setup(11'h40, 12'd16, 8'd0);
        prbs_mode = 1'b1;
        pulse_start();
        prbs_mode = 1'b0;
        wait_done(400);
        check("t6_done_cyc", ncyc, 259);
        check("t6_nbytes", rx_q.size(), 16);
        check("t6_count", tx_count, 16);
`ifdef GPSTX_PRBS_EN
        s = 7'h7F;
        exp_b = '0;
        for (int b = 0; b < 16; b++) begin
            for (int k = 0; k < 8; k++) begin
                fb    = s[6] ^ s[5];
                s     = {s[5:0], fb};
                exp_b = {exp_b[6:0], fb};
            end
            check($sformatf("t6_prbs%0d", b), rx_q[b], exp_b);
        end
`else
        s = '0; exp_b = '0; fb = 1'b0;
        for (int b = 0; b < 16; b++) begin
            exp_b = 8'((64 + b) * 37 + 5);
            check($sformatf("t6_buf%0d", b), rx_q[b], exp_b);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
